// File: rtl/memory_reservation_station.sv
// In-order load/store reservation station: buffers memory ops until base and
// store-data operands arrive (directly or via CDB) and dispatches the oldest one.
module memory_reservation_station #(
   parameter int XLEN            = 64,
   parameter int ROB_INDEX_WIDTH = 8,
   parameter int DEPTH           = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       issue_valid,
   output logic                       issue_ready,
   input  logic [ROB_INDEX_WIDTH-1:0] issue_ROB_index,
   input  logic [XLEN-1:0]            issue_address,
   input  logic                       issue_1st_ready,
   input  logic [XLEN-1:0]            issue_1st_reg,
   input  logic [ROB_INDEX_WIDTH-1:0] issue_1st_tag,
   input  logic                       issue_2nd_ready,
   input  logic [XLEN-1:0]            issue_2nd_reg,
   input  logic [ROB_INDEX_WIDTH-1:0] issue_2nd_tag,
   input  logic                       cdb_valid,
   input  logic [ROB_INDEX_WIDTH-1:0] cdb_ROB_index,
   input  logic [XLEN-1:0]            cdb_value,
   input  logic                       dispatch_ready,
   output logic                       dispatch_valid,
   output logic [XLEN-1:0]            dispatch_1st_reg,
   output logic [XLEN-1:0]            dispatch_2nd_reg,
   output logic [XLEN-1:0]            dispatch_address,
   output logic [ROB_INDEX_WIDTH-1:0] dispatch_ROB_index,
   input  logic                       flush
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   logic [ROB_INDEX_WIDTH-1:0] rob_r  [DEPTH];
   logic [XLEN-1:0]            imm_r  [DEPTH];
   logic [XLEN-1:0]            op1_r  [DEPTH];
   logic [XLEN-1:0]            op2_r  [DEPTH];
   logic [ROB_INDEX_WIDTH-1:0] tag1_r [DEPTH];
   logic [ROB_INDEX_WIDTH-1:0] tag2_r [DEPTH];
   logic [DEPTH-1:0]           rdy1_r;
   logic [DEPTH-1:0]           rdy2_r;
   logic [PTR_W-1:0]           head_r;
   logic [PTR_W-1:0]           tail_r;
   logic [CNT_W-1:0]           count_r;

   logic             issue_fire_s;
   logic             dispatch_fire_s;
   logic             in1_rdy_s;
   logic             in2_rdy_s;
   logic [XLEN-1:0]  in1_val_s;
   logic [XLEN-1:0]  in2_val_s;
   logic [DEPTH-1:0] slot_valid_s;

   // Handshakes, slot occupancy and CDB bypass of the operands being issued.
   always_comb begin
      issue_ready     = (count_r != FULL_COUNT);
      dispatch_valid  = (count_r != {CNT_W{1'b0}}) && rdy1_r[head_r] && rdy2_r[head_r];
      issue_fire_s    = issue_valid && issue_ready;
      dispatch_fire_s = dispatch_valid && dispatch_ready;
      in1_rdy_s       = issue_1st_ready || (cdb_valid && (cdb_ROB_index == issue_1st_tag));
      in2_rdy_s       = issue_2nd_ready || (cdb_valid && (cdb_ROB_index == issue_2nd_tag));
      in1_val_s       = issue_1st_ready ? issue_1st_reg : cdb_value;
      in2_val_s       = issue_2nd_ready ? issue_2nd_reg : cdb_value;
      slot_valid_s    = {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         // A slot is live when its distance from head is below the occupancy count.
         slot_valid_s[i] = ({1'b0, PTR_W'(i) - head_r} < count_r);
      end
   end

   assign dispatch_1st_reg   = op1_r[head_r];
   assign dispatch_2nd_reg   = op2_r[head_r];
   assign dispatch_address   = imm_r[head_r];
   assign dispatch_ROB_index = rob_r[head_r];

   // Slot storage, CDB wakeup, pointer and occupancy bookkeeping.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_r  <= {PTR_W{1'b0}};
         tail_r  <= {PTR_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
         rdy1_r  <= {DEPTH{1'b0}};
         rdy2_r  <= {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            rob_r[i]  <= {ROB_INDEX_WIDTH{1'b0}};
            imm_r[i]  <= {XLEN{1'b0}};
            op1_r[i]  <= {XLEN{1'b0}};
            op2_r[i]  <= {XLEN{1'b0}};
            tag1_r[i] <= {ROB_INDEX_WIDTH{1'b0}};
            tag2_r[i] <= {ROB_INDEX_WIDTH{1'b0}};
         end
      end else if (flush) begin
         head_r  <= {PTR_W{1'b0}};
         tail_r  <= {PTR_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
         rdy1_r  <= {DEPTH{1'b0}};
         rdy2_r  <= {DEPTH{1'b0}};
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid_s[i] && cdb_valid && !rdy1_r[i] && (tag1_r[i] == cdb_ROB_index)) begin
               op1_r[i]  <= cdb_value;
               rdy1_r[i] <= 1'b1;
            end
            if (slot_valid_s[i] && cdb_valid && !rdy2_r[i] && (tag2_r[i] == cdb_ROB_index)) begin
               op2_r[i]  <= cdb_value;
               rdy2_r[i] <= 1'b1;
            end
         end
         // The tail slot is never live while issue is allowed, so this cannot collide with wakeup.
         if (issue_fire_s) begin
            rob_r[tail_r]  <= issue_ROB_index;
            imm_r[tail_r]  <= issue_address;
            op1_r[tail_r]  <= in1_val_s;
            op2_r[tail_r]  <= in2_val_s;
            tag1_r[tail_r] <= issue_1st_tag;
            tag2_r[tail_r] <= issue_2nd_tag;
            rdy1_r[tail_r] <= in1_rdy_s;
            rdy2_r[tail_r] <= in2_rdy_s;
            tail_r         <= tail_r + PTR_W'(1);
         end
         if (dispatch_fire_s) begin
            head_r <= head_r + PTR_W'(1);
         end
         case ({issue_fire_s, dispatch_fire_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end
endmodule

// File: tb/tb_memory_reservation_station.sv
// Randomized and directed bench for memory_reservation_station, checked against
// a queue-based model of the station's ordering and wakeup rules.
module tb_memory_reservation_station;
   localparam int XLEN = 64;
   localparam int RW = 8;
   localparam int DEPTH = 4;

   logic            clock = 1'b0;
   logic            reset;
   logic            issue_valid, issue_ready;
   logic [RW-1:0]   issue_ROB_index;
   logic [XLEN-1:0] issue_address;
   logic            issue_1st_ready;
   logic [XLEN-1:0] issue_1st_reg;
   logic [RW-1:0]   issue_1st_tag;
   logic            issue_2nd_ready;
   logic [XLEN-1:0] issue_2nd_reg;
   logic [RW-1:0]   issue_2nd_tag;
   logic            cdb_valid;
   logic [RW-1:0]   cdb_ROB_index;
   logic [XLEN-1:0] cdb_value;
   logic            dispatch_ready, dispatch_valid;
   logic [XLEN-1:0] dispatch_1st_reg, dispatch_2nd_reg, dispatch_address;
   logic [RW-1:0]   dispatch_ROB_index;
   logic            flush;

   memory_reservation_station #(.XLEN(XLEN), .ROB_INDEX_WIDTH(RW), .DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_ROB_index(issue_ROB_index), .issue_address(issue_address),
      .issue_1st_ready(issue_1st_ready), .issue_1st_reg(issue_1st_reg), .issue_1st_tag(issue_1st_tag),
      .issue_2nd_ready(issue_2nd_ready), .issue_2nd_reg(issue_2nd_reg), .issue_2nd_tag(issue_2nd_tag),
      .cdb_valid(cdb_valid), .cdb_ROB_index(cdb_ROB_index), .cdb_value(cdb_value),
      .dispatch_ready(dispatch_ready), .dispatch_valid(dispatch_valid),
      .dispatch_1st_reg(dispatch_1st_reg), .dispatch_2nd_reg(dispatch_2nd_reg),
      .dispatch_address(dispatch_address), .dispatch_ROB_index(dispatch_ROB_index),
      .flush(flush)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [RW-1:0]   rob;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] v1;
      logic [XLEN-1:0] v2;
      logic            r1;
      logic            r2;
      logic [RW-1:0]   t1;
      logic [RW-1:0]   t2;
   } ent_t;

   ent_t q[$];
   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      issue_valid = 1'b0; issue_ROB_index = '0; issue_address = '0;
      issue_1st_ready = 1'b1; issue_1st_reg = '0; issue_1st_tag = '0;
      issue_2nd_ready = 1'b1; issue_2nd_reg = '0; issue_2nd_tag = '0;
      cdb_valid = 1'b0; cdb_ROB_index = '0; cdb_value = '0;
      dispatch_ready = 1'b0; flush = 1'b0;
   endtask

   task automatic set_issue(input logic [RW-1:0] rob, input logic [XLEN-1:0] imm,
                            input logic r1, input logic [XLEN-1:0] v1, input logic [RW-1:0] t1,
                            input logic r2, input logic [XLEN-1:0] v2, input logic [RW-1:0] t2);
      issue_valid = 1'b1; issue_ROB_index = rob; issue_address = imm;
      issue_1st_ready = r1; issue_1st_reg = v1; issue_1st_tag = t1;
      issue_2nd_ready = r2; issue_2nd_reg = v2; issue_2nd_tag = t2;
   endtask

   // Model: the station is an ordered list; the oldest leaves when both operands are known.
   task automatic model_edge();
      bit   head_ok, dfire, ifire;
      ent_t e;
      if (!reset || flush) begin
         q.delete();
      end else begin
         head_ok = (q.size() != 0) && q[0].r1 && q[0].r2;
         dfire   = head_ok && dispatch_ready;
         ifire   = issue_valid && (q.size() != DEPTH);
         if (dfire) void'(q.pop_front());
         if (cdb_valid) begin
            foreach (q[k]) begin
               if (!q[k].r1 && q[k].t1 == cdb_ROB_index) begin q[k].v1 = cdb_value; q[k].r1 = 1'b1; end
               if (!q[k].r2 && q[k].t2 == cdb_ROB_index) begin q[k].v2 = cdb_value; q[k].r2 = 1'b1; end
            end
         end
         if (ifire) begin
            e.rob = issue_ROB_index; e.imm = issue_address; e.t1 = issue_1st_tag; e.t2 = issue_2nd_tag;
            e.r1 = issue_1st_ready || (cdb_valid && cdb_ROB_index == issue_1st_tag);
            e.r2 = issue_2nd_ready || (cdb_valid && cdb_ROB_index == issue_2nd_tag);
            e.v1 = issue_1st_ready ? issue_1st_reg : cdb_value;
            e.v2 = issue_2nd_ready ? issue_2nd_reg : cdb_value;
            q.push_back(e);
         end
      end
   endtask

   task automatic compare_all();
      bit exp_dv;
      exp_dv = (q.size() != 0) && q[0].r1 && q[0].r2;
      chk("issue_ready", {63'd0, issue_ready}, {63'd0, q.size() != DEPTH});
      chk("dispatch_valid", {63'd0, dispatch_valid}, {63'd0, exp_dv});
      if (exp_dv) begin
         chk("dispatch_ROB_index", {56'd0, dispatch_ROB_index}, {56'd0, q[0].rob});
         chk("dispatch_1st_reg", dispatch_1st_reg, q[0].v1);
         chk("dispatch_2nd_reg", dispatch_2nd_reg, q[0].v2);
         chk("dispatch_address", dispatch_address, q[0].imm);
      end
   endtask

   // Inputs are changed only at the falling edge; the model steps at the rising edge.
   task automatic cycle();
      @(posedge clock);
      model_edge();
      @(negedge clock);
      compare_all();
   endtask

   initial begin
      idle();
      reset = 1'b0;
      @(negedge clock);
      @(negedge clock);
      chk("rst_dispatch_valid", {63'd0, dispatch_valid}, 64'd0);
      chk("rst_issue_ready", {63'd0, issue_ready}, 64'd1);
      chk("rst_1st_reg", dispatch_1st_reg, 64'd0);
      chk("rst_rob", {56'd0, dispatch_ROB_index}, 64'd0);
      reset = 1'b1;
      cycle();

      // Fully ready op dispatches the cycle after issue.
      dispatch_ready = 1'b1;
      set_issue(8'd5, 64'h10, 1'b1, 64'h1000, 8'd0, 1'b1, 64'hAA, 8'd0);
      cycle();
      issue_valid = 1'b0;
      chk("t1_valid", {63'd0, dispatch_valid}, 64'd1);
      chk("t1_rob", {56'd0, dispatch_ROB_index}, 64'd5);
      chk("t1_1st", dispatch_1st_reg, 64'h1000);
      chk("t1_2nd", dispatch_2nd_reg, 64'hAA);
      chk("t1_imm", dispatch_address, 64'h10);
      cycle();
      chk("t1_drained", {63'd0, dispatch_valid}, 64'd0);

      // Wakeup from CDB.
      set_issue(8'd3, 64'h8, 1'b0, 64'h0, 8'd7, 1'b1, 64'h1, 8'd0);
      cycle();
      issue_valid = 1'b0;
      cycle();
      chk("t2_waiting", {63'd0, dispatch_valid}, 64'd0);
      cdb_valid = 1'b1; cdb_ROB_index = 8'd7; cdb_value = 64'h2000;
      cycle();
      cdb_valid = 1'b0;
      chk("t2_woken", {63'd0, dispatch_valid}, 64'd1);
      chk("t2_1st", dispatch_1st_reg, 64'h2000);
      cycle();

      // Same-cycle CDB bypass on issue.
      set_issue(8'd11, 64'h0, 1'b0, 64'h0, 8'd9, 1'b1, 64'h2, 8'd0);
      cdb_valid = 1'b1; cdb_ROB_index = 8'd9; cdb_value = 64'h44;
      cycle();
      idle(); dispatch_ready = 1'b1;
      chk("t3_bypass_valid", {63'd0, dispatch_valid}, 64'd1);
      chk("t3_bypass_1st", dispatch_1st_reg, 64'h44);
      cycle();

      // Stalled head blocks a ready younger op.
      set_issue(8'd30, 64'h0, 1'b0, 64'h0, 8'd2, 1'b1, 64'h3, 8'd0);
      cycle();
      set_issue(8'd31, 64'h0, 1'b1, 64'h5, 8'd0, 1'b1, 64'h6, 8'd0);
      cycle();
      issue_valid = 1'b0;
      cycle();
      chk("t4_stall", {63'd0, dispatch_valid}, 64'd0);
      cdb_valid = 1'b1; cdb_ROB_index = 8'd2; cdb_value = 64'h77;
      cycle();
      cdb_valid = 1'b0;
      chk("t4_head_a", {56'd0, dispatch_ROB_index}, 64'd30);
      cycle();
      chk("t4_then_b", {56'd0, dispatch_ROB_index}, 64'd31);
      cycle();

      // Fill, hold fifth op while full, then stream across pointer wrap.
      dispatch_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_issue(8'(20 + i), 64'(i), 1'b1, 64'(100 + i), 8'd0, 1'b1, 64'd0, 8'd0);
         cycle();
      end
      chk("t5_full", {63'd0, issue_ready}, 64'd0);
      set_issue(8'd99, 64'd0, 1'b1, 64'd0, 8'd0, 1'b1, 64'd0, 8'd0);
      dispatch_ready = 1'b1;
      cycle();
      chk("t5_held_head", {56'd0, dispatch_ROB_index}, 64'd21);
      for (int i = 0; i < 6; i++) begin
         set_issue(8'(40 + i), 64'(i), 1'b1, 64'(200 + i), 8'd0, 1'b1, 64'd1, 8'd0);
         cycle();
      end
      issue_valid = 1'b0;
      for (int i = 0; i < 5; i++) cycle();

      // Flush drops queued ops and a same-cycle issue.
      dispatch_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_issue(8'(50 + i), 64'd0, 1'b1, 64'd1, 8'd0, 1'b1, 64'd1, 8'd0);
         cycle();
      end
      flush = 1'b1;
      cycle();
      flush = 1'b0; issue_valid = 1'b0;
      chk("t6_flush_valid", {63'd0, dispatch_valid}, 64'd0);
      chk("t6_flush_ready", {63'd0, issue_ready}, 64'd1);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         issue_valid = ($urandom_range(0, 2) != 0);
         issue_ROB_index = 8'($urandom);
         issue_address = {$urandom, $urandom};
         issue_1st_ready = $urandom_range(0, 1) == 1;
         issue_1st_reg = {$urandom, $urandom};
         issue_1st_tag = 8'($urandom_range(0, 7));
         issue_2nd_ready = $urandom_range(0, 2) != 0;
         issue_2nd_reg = {$urandom, $urandom};
         issue_2nd_tag = 8'($urandom_range(0, 7));
         cdb_valid = $urandom_range(0, 1) == 1;
         cdb_ROB_index = 8'($urandom_range(0, 7));
         cdb_value = {$urandom, $urandom};
         dispatch_ready = $urandom_range(0, 3) != 0;
         flush = ($urandom_range(0, 60) == 0);
         cycle();
      end

      // Asynchronous reset mid-operation.
      idle();
      set_issue(8'd60, 64'd0, 1'b1, 64'h9, 8'd0, 1'b1, 64'h9, 8'd0);
      cycle();
      issue_valid = 1'b0;
      chk("t7_before_reset", {63'd0, dispatch_valid}, 64'd1);
      #2;
      reset = 1'b0;
      #1;
      q.delete();
      chk("t7_async_valid", {63'd0, dispatch_valid}, 64'd0);
      chk("t7_async_ready", {63'd0, issue_ready}, 64'd1);
      chk("t7_async_1st", dispatch_1st_reg, 64'd0);
      @(negedge clock);
      reset = 1'b1;
      cycle();
      cycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
